alu_op_sequencer: RTL
=====================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  system clock, rising edge.
REQ-002 SHALL have ports: clear  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: start  in  1  one-cycle request, sampled in IDLE only.
REQ-004 SHALL have ports: ir  in  32  instruction: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15], imm ir[18:0].
REQ-005 SHALL have ports: rf_rd_data  in  32  register-file read data for the selected register.
REQ-006 SHALL have ports: z_in  in  64  ALU result C.
REQ-007 SHALL have ports: rf_rd_sel  out  4  register-file read select.
REQ-008 SHALL have ports: y_load  out  1  load Y (ALU A operand) from rf_rd_data.
REQ-009 SHALL have ports: alu_b  out  32  ALU B operand (rf_rd_data or sign-extended imm).
REQ-010 SHALL have ports: alu_opcode  out  5  opcode to ALU, held for the whole operation.
REQ-011 SHALL have ports: rf_wr_en / rf_wr_sel / wb_data  out  1/4/32  register-file writeback.
REQ-012 SHALL have ports: lo_wr / hi_wr  out  1/1  LO/HI register write strobes (data on wb_data).
REQ-013 SHALL have ports: busy, done, illegal  out  1  status; done and illegal are one-cycle pulses.

Function
REQ-014 SHALL capture ir on accepted start; later ir changes SHALL NOT affect the operation.
REQ-015 SHALL use states IDLE, LOAD_Y, EXEC, WB_LO, WB_HI, DONE.
REQ-016 SHALL decode opcodes 5'b00011 add, 00100 sub, 00101 and, 00110 or, 00111 ror, 01000 rol, 01001 shr, 01010 shra, 01011 shl, 01100 addi, 01101 andi, 01110 ori, 01111 div, 10000 mul, 10001 neg, 10010 not; all others illegal.
REQ-017 IDLE + start + legal: -> LOAD_Y; rf_rd_sel=rb (ra for mul/div), y_load=1 for one cycle.
REQ-018 EXEC: rf_rd_sel=rc (rb for mul/div/neg/not); alu_b=sign-extended imm for immediate ops, else rf_rd_data; internal 64-bit Z register captures z_in at end of EXEC.
REQ-019 WB_LO: wb_data=Z[31:0]; 32-bit ops assert rf_wr_en with rf_wr_sel=ra; mul/div assert lo_wr instead; next state DONE (32-bit) or WB_HI (mul/div).
REQ-020 WB_HI: wb_data=Z[63:32], hi_wr=1; -> DONE.
REQ-021 DONE: done=1 one cycle; -> IDLE.
REQ-022 Latency from start cycle: done at +4 for 32-bit ops, +5 for mul/div.
REQ-023 IDLE + start + illegal opcode: -> DONE directly; illegal=1 coincident with done; no write strobe.
REQ-024 busy=1 in every state except IDLE; start while busy SHALL be ignored.
REQ-025 Exactly one write strobe per writeback cycle; strobes low in all other states.
REQ-026 Divide-by-zero SHALL NOT be special-cased; Z is written back as produced.

Reset
REQ-027 clear SHALL force IDLE asynchronously, including mid-operation, with no partial writeback afterwards.
REQ-028 Reset values: all strobes, busy, done, illegal = 0; alu_opcode, rf_rd_sel, rf_wr_sel, alu_b, wb_data, Z, captured ir = 0.

Configuration
REQ-029 Macro ALU_SEQ_IMM_EN defined: addi/andi/ori legal, B operand from sign-extended ir[18:0].
REQ-030 Macro ALU_SEQ_IMM_EN undefined: opcodes 01100-01110 decode as illegal (REQ-023); no immediate mux.

Structure
REQ-031 Opcode constants, state enum and ir field positions SHALL live in a shared package, also used by the ALU.
REQ-032 One sub-module alu_op_decode (combinational: opcode -> legal, is_imm, is_unary, is_wide).

Verification
REQ-033 add, ra=1 rb=2 rc=3, R2=5 R3=7 -> rf_wr_en at +3, rf_wr_sel=1, wb_data=12; done at +4.
REQ-034 mul, z_in=64'h0000_0002_0000_0003 -> lo_wr at +3 data 3, hi_wr at +4 data 2, done at +5, rf_wr_en never.
REQ-035 opcode 5'b11111 -> illegal and done at +1, no strobes, busy high one cycle.
REQ-036 addi imm=19'h7FFFF -> alu_b=32'hFFFF_FFFF with macro; illegal pulse without macro.
REQ-037 clear asserted during EXEC -> IDLE immediately, no rf_wr_en/lo_wr/hi_wr afterwards, outputs at reset values.
REQ-038 start re-pulsed during busy -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer and the ALU: opcodes,
// instruction field positions, sequencer states and immediate sign extension.
package alu_op_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int WIDE_W = 2 * DATA_W;
    localparam int IMM_W  = 19;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int IMM_MSB = 18;
    localparam int IMM_LSB = 0;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_Y,
        S_EXEC,
        S_WB_LO,
        S_WB_HI,
        S_DONE
    } state_e;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic signed [IMM_W-1:0] imm);
        return DATA_W'(imm);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Bus between the sequencer and its register file / ALU environment.
interface alu_op_sequencer_if;
    import alu_op_sequencer_pkg::*;

    logic              start;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] rf_rd_data;
    logic [WIDE_W-1:0] z_in;
    logic [3:0]        rf_rd_sel;
    logic              y_load;
    logic [DATA_W-1:0] alu_b;
    logic [4:0]        alu_opcode;
    logic              rf_wr_en;
    logic [3:0]        rf_wr_sel;
    logic [DATA_W-1:0] wb_data;
    logic              lo_wr;
    logic              hi_wr;
    logic              busy;
    logic              done;
    logic              illegal;

    modport master (
        output start, ir, rf_rd_data, z_in,
        input  rf_rd_sel, y_load, alu_b, alu_opcode, rf_wr_en, rf_wr_sel,
               wb_data, lo_wr, hi_wr, busy, done, illegal
    );

    modport slave (
        input  start, ir, rf_rd_data, z_in,
        output rf_rd_sel, y_load, alu_b, alu_opcode, rf_wr_en, rf_wr_sel,
               wb_data, lo_wr, hi_wr, busy, done, illegal
    );

endinterface

// File: rtl/alu_op_sequencer_decode.sv
// Opcode classifier for the sequencer. Immediate ops are legal only when
// ALU_SEQ_IMM_EN is defined.
module alu_op_decode
    import alu_op_sequencer_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       legal,
    output logic       is_imm,
    output logic       is_unary,
    output logic       is_wide
);

    always_comb begin
        legal    = 1'b0;
        is_imm   = 1'b0;
        is_unary = 1'b0;
        is_wide  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: legal = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI: begin
`ifdef ALU_SEQ_IMM_EN
                legal  = 1'b1;
                is_imm = 1'b1;
`endif
            end
            OP_DIV, OP_MUL: begin
                legal   = 1'b1;
                is_wide = 1'b1;
            end
            OP_NEG, OP_NOT: begin
                legal    = 1'b1;
                is_unary = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU operation sequencer: LOAD_Y -> EXEC -> writeback -> DONE.
// ALU_SEQ_IMM_EN enables the addi/andi/ori immediate B-operand path.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input logic               clock,
    input logic               clear,
    alu_op_sequencer_if.slave bus
);

    state_e            state;
    logic [DATA_W-1:0] ir_q;
    logic [WIDE_W-1:0] z_q;
    logic              is_imm_q;
    logic              is_unary_q;
    logic              is_wide_q;
    logic [3:0]        rd_sel_q;
    logic [3:0]        wr_sel_q;
    logic [DATA_W-1:0] wb_data_q;
    logic              y_load_q;
    logic              wr_en_q;
    logic              lo_wr_q;
    logic              hi_wr_q;
    logic              busy_q;
    logic              done_q;
    logic              illegal_q;
    logic [DATA_W-1:0] alu_b_c;

    logic dec_legal, dec_imm, dec_unary, dec_wide;

    alu_op_decode u_decode (
        .opcode   (bus.ir[OPC_MSB:OPC_LSB]),
        .legal    (dec_legal),
        .is_imm   (dec_imm),
        .is_unary (dec_unary),
        .is_wide  (dec_wide)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state      <= S_IDLE;
            ir_q       <= '0;
            z_q        <= '0;
            is_imm_q   <= 1'b0;
            is_unary_q <= 1'b0;
            is_wide_q  <= 1'b0;
            rd_sel_q   <= '0;
            wr_sel_q   <= '0;
            wb_data_q  <= '0;
            y_load_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            lo_wr_q    <= 1'b0;
            hi_wr_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            // Strobes and pulses default low; each state raises only its own.
            y_load_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            lo_wr_q   <= 1'b0;
            hi_wr_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ir_q   <= bus.ir;
                        busy_q <= 1'b1;
                        if (dec_legal) begin
                            state      <= S_LOAD_Y;
                            y_load_q   <= 1'b1;
                            rd_sel_q   <= dec_wide ? bus.ir[RA_MSB:RA_LSB] : bus.ir[RB_MSB:RB_LSB];
                            is_imm_q   <= dec_imm;
                            is_unary_q <= dec_unary;
                            is_wide_q  <= dec_wide;
                        end else begin
                            state     <= S_DONE;
                            done_q    <= 1'b1;
                            illegal_q <= 1'b1;
                        end
                    end
                end
                S_LOAD_Y: begin
                    state    <= S_EXEC;
                    rd_sel_q <= (is_wide_q || is_unary_q) ? ir_q[RB_MSB:RB_LSB] : ir_q[RC_MSB:RC_LSB];
                end
                S_EXEC: begin
                    state     <= S_WB_LO;
                    z_q       <= bus.z_in;
                    wb_data_q <= bus.z_in[DATA_W-1:0];
                    if (is_wide_q) begin
                        lo_wr_q <= 1'b1;
                    end else begin
                        wr_en_q  <= 1'b1;
                        wr_sel_q <= ir_q[RA_MSB:RA_LSB];
                    end
                end
                S_WB_LO: begin
                    if (is_wide_q) begin
                        state     <= S_WB_HI;
                        wb_data_q <= z_q[WIDE_W-1:DATA_W];
                        hi_wr_q   <= 1'b1;
                    end else begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_WB_HI: begin
                    state  <= S_DONE;
                    done_q <= 1'b1;
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // B operand follows the live register-file read during EXEC.
    always_comb begin
        alu_b_c = '0;
        if (state == S_EXEC) begin
`ifdef ALU_SEQ_IMM_EN
            alu_b_c = is_imm_q ? sext_imm(ir_q[IMM_MSB:IMM_LSB]) : bus.rf_rd_data;
`else
            alu_b_c = bus.rf_rd_data;
`endif
        end
    end

`ifndef ALU_SEQ_IMM_EN
    logic unused_imm_fields;
    assign unused_imm_fields = ^{ir_q[RC_LSB-1:IMM_LSB], is_imm_q};
`endif

    assign bus.rf_rd_sel  = rd_sel_q;
    assign bus.y_load     = y_load_q;
    assign bus.alu_b      = alu_b_c;
    assign bus.alu_opcode = ir_q[OPC_MSB:OPC_LSB];
    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_sel  = wr_sel_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.lo_wr      = lo_wr_q;
    assign bus.hi_wr      = hi_wr_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.illegal    = illegal_q;

endmodule
